// File: rtl/ryuki_datatypes.sv
// Shared trace types: completed-record layout, word count at the default output width,
// and the serializer state encoding.
package ryuki_datatypes;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd_addr;
      logic        rd_we;
      logic [31:0] rd_data;
   } trace_output;

   localparam int TRACE_BITS      = $bits(trace_output);
   localparam int TRACE_OUT_WIDTH = 32;
   localparam int TRACE_WORDS     = (TRACE_BITS + TRACE_OUT_WIDTH - 1) / TRACE_OUT_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } ser_state_e;

   function automatic int trace_words_for(input int width);
      return (TRACE_BITS + width - 1) / width;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with wrap-bit pointers; push ignored when full, pop ignored when empty.
// Head element is visible combinationally on pop_data.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty    = (wr_ptr == rd_ptr);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: occupancy is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/trace_collector.sv
// Buffers completed trace records and serializes each one LSB word first over a valid/ready port.
// TRACE_COLLECTOR_TIMESTAMP_EN prepends the push-time counter value as an extra leading word.
module trace_collector
   import ryuki_datatypes::*;
#(
   parameter int DEPTH     = 8,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  integer               counter,
   input  logic                 trace_valid_i,
   input  trace_output          trace_data_i,
   output logic                 trace_ready_o,
   output logic                 out_valid_o,
   output logic [OUT_WIDTH-1:0] out_data_o,
   output logic                 out_last_o,
   input  logic                 out_ready_i,
   output logic                 overflow_o,
   output logic [15:0]          drop_count_o
);

   localparam int DATA_WORDS = trace_words_for(OUT_WIDTH);
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   localparam int NUM_WORDS  = DATA_WORDS + 1;
   localparam int ELEM_W     = TRACE_BITS + OUT_WIDTH;
`else
   localparam int NUM_WORDS  = DATA_WORDS;
   localparam int ELEM_W     = TRACE_BITS;
`endif
   localparam int SHIFT_W    = NUM_WORDS * OUT_WIDTH;
   localparam int IDX_W      = $clog2(NUM_WORDS + 1);

   ser_state_e         state;
   ser_state_e         state_nxt;
   logic [ELEM_W-1:0]  fifo_in;
   logic [ELEM_W-1:0]  fifo_out;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push_ok;
   logic               pop;
   logic [SHIFT_W-1:0] shreg;
   logic [IDX_W-1:0]   word_idx;
   logic               word_last;

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   logic [31:0]          counter_u;
   logic [OUT_WIDTH-1:0] stamp;

   // Timestamp occupies the low word so it leaves the shifter first.
   assign counter_u = counter;
   assign stamp     = OUT_WIDTH'(counter_u);
   assign fifo_in   = {trace_data_i, stamp};
`else
   logic unused_counter;

   assign unused_counter = ^counter;
   assign fifo_in        = trace_data_i;
`endif

   assign push_ok       = trace_valid_i && !fifo_full;
   assign trace_ready_o = !fifo_full;

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ELEM_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ok),
      .push_data (fifo_in),
      .pop       (pop),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign word_last   = (word_idx == IDX_W'(NUM_WORDS - 1));
   assign out_valid_o = (state == SEND);
   assign out_last_o  = (state == SEND) && word_last;
   assign out_data_o  = shreg[OUT_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) state_nxt = LOAD;
         end
         LOAD: begin
            pop       = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            // A push landing on the final handshake counts as non-empty after the edge.
            if (out_ready_i && word_last)
               state_nxt = (!fifo_empty || push_ok) ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         word_idx <= '0;
      end else if (state == LOAD) begin
         shreg    <= SHIFT_W'(fifo_out);
         word_idx <= '0;
      end else if ((state == SEND) && out_ready_i) begin
         shreg    <= shreg >> OUT_WIDTH;
         word_idx <= word_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_o   <= 1'b0;
         drop_count_o <= '0;
      end else if (trace_valid_i && fifo_full) begin
         overflow_o <= 1'b1;
         if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_trace_collector.sv
// Randomized and directed bench for trace_collector against a word-queue scoreboard.
module tb_trace_collector;
   import ryuki_datatypes::*;

   localparam int DEPTH   = 8;
   localparam int OW      = 32;
   localparam int TB_BITS = $bits(trace_output);
   localparam int NW_DATA = (TB_BITS + OW - 1) / OW;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   localparam int NW      = NW_DATA + 1;
`else
   localparam int NW      = NW_DATA;
`endif

   logic          clk = 1'b0;
   logic          rst;
   integer        cnt;
   logic          trace_valid_i;
   trace_output   trace_data_i;
   logic          trace_ready_o;
   logic          out_valid_o;
   logic [OW-1:0] out_data_o;
   logic          out_last_o;
   logic          out_ready_i;
   logic          overflow_o;
   logic [15:0]   drop_count_o;

   trace_collector #(.DEPTH(DEPTH), .OUT_WIDTH(OW)) dut (
      .clk           (clk),
      .rst           (rst),
      .counter       (cnt),
      .trace_valid_i (trace_valid_i),
      .trace_data_i  (trace_data_i),
      .trace_ready_o (trace_ready_o),
      .out_valid_o   (out_valid_o),
      .out_data_o    (out_data_o),
      .out_last_o    (out_last_o),
      .out_ready_i   (out_ready_i),
      .overflow_o    (overflow_o),
      .drop_count_o  (drop_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] dat;
      logic          last;
   } word_t;

   int            checks   = 0;
   int            errors   = 0;
   int            drop_exp = 0;
   word_t         exp_q[$];
   bit            mon_en   = 1'b0;
   bit            stalled  = 1'b0;
   logic [OW-1:0] held_dat;
   logic          held_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cnt = cnt + 1;
   endtask

   function automatic trace_output rand_rec();
      logic [NW_DATA*OW-1:0] b;
      for (int k = 0; k < NW_DATA; k++) b[k*OW +: OW] = $urandom;
      return b[TB_BITS-1:0];
   endfunction

   // Expected stream: optional stamp word, then record words LSB first with zero padding.
   task automatic expect_rec(input trace_output r, input logic [OW-1:0] ts);
      logic [NW_DATA*OW-1:0] flat;
      flat = '0;
      flat[TB_BITS-1:0] = r;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      exp_q.push_back('{dat: ts, last: 1'b0});
`endif
      for (int k = 0; k < NW_DATA; k++)
         exp_q.push_back('{dat: flat[k*OW +: OW], last: (k == NW_DATA - 1)});
   endtask

   task automatic push(input trace_output r, input bit accept);
      trace_data_i  = r;
      trace_valid_i = 1'b1;
      if (accept) expect_rec(r, cnt);
      else        drop_exp++;
      step();
      trace_valid_i = 1'b0;
   endtask

   task automatic drain(input int budget);
      out_ready_i = 1'b1;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
      check("drain_empty", exp_q.size(), 0);
      repeat (2) step();
   endtask

   always @(negedge clk) begin
      if (rst || !mon_en) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", out_valid_o, 1'b1);
            check("stall_data", out_data_o, held_dat);
            check("stall_last", out_last_o, held_last);
         end
         stalled = 1'b0;
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               check("spurious_word", out_valid_o, 1'b0);
            end else begin
               word_t e;
               e = exp_q.pop_front();
               check("word_data", out_data_o, e.dat);
               check("word_last", out_last_o, e.last);
            end
         end else if (out_valid_o) begin
            stalled   = 1'b1;
            held_dat  = out_data_o;
            held_last = out_last_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      trace_output r;
      int          pr;

      rst           = 1'b1;
      cnt           = 0;
      trace_valid_i = 1'b1;
      trace_data_i  = rand_rec();
      out_ready_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      trace_valid_i = 1'b0;
      check("rst_valid", out_valid_o, 1'b0);
      check("rst_last", out_last_o, 1'b0);
      check("rst_data", out_data_o, 0);
      rst = 1'b0;
      step();
      check("rst_ready", trace_ready_o, 1'b1);
      check("rst_overflow", overflow_o, 1'b0);
      check("rst_drop", drop_count_o, 0);
      check("rst_no_push", out_valid_o, 1'b0);
      mon_en = 1'b1;

      // Single record latency and first word.
      out_ready_i = 1'b1;
      r = rand_rec();
      r[31:0] = 32'hDEADBEEF;
      cnt = 100;
      push(r, 1'b1);
      check("lat_edge1", out_valid_o, 1'b0);
      step();
      check("lat_edge1b", out_valid_o, 1'b0);
      step();
      check("lat_word0_valid", out_valid_o, 1'b1);
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      check("lat_word0_data", out_data_o, 32'h00000064);
`else
      check("lat_word0_data", out_data_o, 32'hDEADBEEF);
`endif
      drain(50);

      // Five-cycle stall mid-record.
      push(rand_rec(), 1'b1);
      push(rand_rec(), 1'b1);
      for (int i = 0; i < 10 && !out_valid_o; i++) step();
      check("stall_start", out_valid_o, 1'b1);
      step();
      out_ready_i = 1'b0;
      repeat (5) step();
      drain(100);

      // Overflow with serializer busy: 8 of 10 accepted.
      out_ready_i = 1'b0;
      push(rand_rec(), 1'b1);
      repeat (2) step();
      for (int i = 0; i < 10; i++) begin
         push(rand_rec(), i < DEPTH);
         if (i == DEPTH - 1) check("full_after_8", trace_ready_o, 1'b0);
      end
      check("ovf_sticky", overflow_o, 1'b1);
      check("ovf_drop2", drop_count_o, drop_exp);
      drain(400);

      // Push on the LOAD edge while full is rejected, next one accepted.
      out_ready_i = 1'b0;
      push(rand_rec(), 1'b1);
      repeat (2) step();
      for (int i = 0; i < DEPTH; i++) push(rand_rec(), 1'b1);
      check("full_before_load", trace_ready_o, 1'b0);
      out_ready_i = 1'b1;
      repeat (NW) step();
      check("full_at_load", trace_ready_o, 1'b0);
      push(rand_rec(), 1'b0);
      check("load_edge_drop", drop_count_o, drop_exp);
      push(rand_rec(), 1'b1);
      check("after_load_drop", drop_count_o, drop_exp);
      drain(400);

      // Reset during word 1 with three records buffered.
      out_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) push(rand_rec(), 1'b1);
      for (int i = 0; i < 10 && !out_valid_o; i++) step();
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid_o, 1'b0);
      check("mid_rst_last", out_last_o, 1'b0);
      check("mid_rst_data", out_data_o, 0);
      exp_q.delete();
      drop_exp = 0;
      step();
      rst = 1'b0;
      out_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid_o) check("post_rst_silent", out_valid_o, 1'b0);
      end
      check("post_rst_idle", out_valid_o, 1'b0);
      check("post_rst_ready", trace_ready_o, 1'b1);
      check("post_rst_ovf", overflow_o, 1'b0);
      check("post_rst_drop", drop_count_o, 0);
      push(rand_rec(), 1'b1);
      drain(50);

      // Random traffic with varying downstream throughput.
      for (int blk = 0; blk < 6; blk++) begin
         pr = (blk == 2) ? 0 : $urandom_range(20, 100);
         for (int i = 0; i < 150; i++) begin
            out_ready_i = ($urandom_range(0, 99) < pr);
            if ($urandom_range(0, 2) == 0) push(rand_rec(), trace_ready_o);
            else                           step();
         end
      end
      drain(1000);
      check("rand_drop", drop_count_o, drop_exp);
      check("rand_ovf", overflow_o, drop_exp != 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
